// File: rtl/cic_pkg.sv
// cic_pkg: constants, types and os_sel helpers shared by the CIC integrator and comb halves.
package cic_pkg;

    localparam int IDW_DEF = 23;
    localparam logic [2:0] OS_SEL_OFF = 3'd0;

    typedef logic [1:0] flag_t;

    // Both all-zeros and all-ones encodings disable the path.
    function automatic logic os_sel_valid(input logic [2:0] os);
        return os != OS_SEL_OFF && os != ~OS_SEL_OFF;
    endfunction

    function automatic logic [7:0] os_ratio(input logic [2:0] os);
        return os_sel_valid(os) ? 8'd1 << (os + 3'd1) : 8'd0;
    endfunction

endpackage

// File: rtl/cic_integ_stage.sv
// cic_integ_stage: one modulo-2^AW accumulator with enable and synchronous clear.
module cic_integ_stage #(
    parameter int AW = 25
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_en,
    input  logic          i_clr,
    input  logic [AW-1:0] i_add,
    output logic [AW-1:0] o_acc
);

    logic [AW-1:0] r_acc;

    always_ff @(posedge clk)
        if (reset || i_clr) r_acc <= '0;
        else if (i_en) r_acc <= r_acc + i_add;

    assign o_acc = r_acc;

endmodule

// File: rtl/cic_integ_decim.sv
// cic_integ_decim: NS cascaded integrators decimated by R = 2^(os_sel+1),
// delivering the last integrator's low IDW bits plus a 2-bit wrap flag.
module cic_integ_decim
    import cic_pkg::*;
#(
    parameter int IW  = 4,
    parameter int IDW = IDW_DEF,
    parameter int NS  = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2:0]     os_sel,
    input  logic           in_valid,
    input  logic [IW-1:0]  data_in,
    output logic [IDW-1:0] data_out,
    output logic [1:0]     flag_out,
    output logic           out_valid
);

    localparam int AW = IDW + 2;

    logic [2:0]     r_os;
    logic [6:0]     r_cnt;
    logic           r_pend;
    logic [IDW-1:0] r_data;
    flag_t          r_flag;
    logic           r_valid;
    logic           w_flush;
    logic           w_en;
    logic           w_last;
    logic [AW-1:0]  w_acc [NS+1];

    assign w_flush  = os_sel != r_os;
    assign w_en     = !w_flush && os_sel_valid(r_os) && in_valid;
    assign w_last   = r_cnt == 7'(os_ratio(r_os) - 8'd1);
    assign w_acc[0] = {{(AW-IW){data_in[IW-1]}}, data_in};

    // Each stage adds the previous stage's registered value, forming the chain.
    for (genvar k = 0; k < NS; k++) begin : g_stage
        cic_integ_stage #(.AW(AW)) u_stage (
            .clk   (clk),
            .reset (reset),
            .i_en  (w_en),
            .i_clr (w_flush),
            .i_add (w_acc[k]),
            .o_acc (w_acc[k+1])
        );
    end

    always_ff @(posedge clk)
        if (reset) begin
            r_os    <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_data  <= '0;
            r_flag  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_os    <= os_sel;
            r_valid <= r_pend && !w_flush;
            if (r_pend && !w_flush) {r_flag, r_data} <= w_acc[NS];
            if (w_flush) begin
                r_cnt  <= '0;
                r_pend <= 1'b0;
            end else begin
                r_pend <= w_en && w_last;
                if (w_en) r_cnt <= w_last ? 7'd0 : r_cnt + 7'd1;
            end
        end

    assign data_out  = r_data;
    assign flag_out  = r_flag;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_cic_integ_decim.sv
// tb_cic_integ_decim: randomized and directed checks of two configurations
// (NS=3/IDW=23 and NS=1/IDW=8) against a closed-form binomial-sum model.
module tb_cic_integ_decim;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  os_sel = 3'd0;
    logic [3:0]  data_in = 4'd0;
    logic [22:0] data_out;
    logic [1:0]  flag_out;
    logic        out_valid;
    logic [7:0]  data_b;
    logic [1:0]  flag_b;
    logic        valid_b;

    int vec = 0;
    int fails = 0;

    // Model state: samples accepted since the last flush, plus the expected outputs.
    int          q[$];
    logic [2:0]  shadow = 3'd0;
    bit          pend = 1'b0;
    bit          ev = 1'b0;
    logic [24:0] ea = '0;
    logic [24:0] cap_a = '0;
    logic [9:0]  eb = '0;
    logic [9:0]  cap_b = '0;

    always #5 clk = ~clk;

    cic_integ_decim #(.IW(4), .IDW(23), .NS(3)) dut_a (
        .clk(clk), .reset(reset), .os_sel(os_sel), .in_valid(in_valid), .data_in(data_in),
        .data_out(data_out), .flag_out(flag_out), .out_valid(out_valid)
    );

    cic_integ_decim #(.IW(4), .IDW(8), .NS(1)) dut_b (
        .clk(clk), .reset(reset), .os_sel(os_sel), .in_valid(in_valid), .data_in(data_in),
        .data_out(data_b), .flag_out(flag_b), .out_valid(valid_b)
    );

    function automatic longint binom(int a, int b);
        longint r = 1;
        if (b > a) return 0;
        for (int i = 0; i < b; i++) r = r * (a - i) / (i + 1);
        return r;
    endfunction

    // After n samples x_1..x_n, the NS-th registered integrator holds sum x_j * C(n-j, NS-1).
    function automatic longint model(int ns, int aw);
        longint s = 0;
        for (int j = 0; j < q.size(); j++) s += longint'(q[j]) * binom(q.size() - 1 - j, ns - 1);
        return s & ((longint'(1) << aw) - 1);
    endfunction

    task automatic tick();
        bit fl;
        int r;
        @(posedge clk);
        if (reset) begin
            q.delete();
            shadow = 3'd0;
            pend = 1'b0;
            ev = 1'b0;
            ea = '0;
            eb = '0;
        end else begin
            fl = os_sel != shadow;
            ev = pend && !fl;
            if (ev) begin
                ea = cap_a;
                eb = cap_b;
            end
            pend = 1'b0;
            r = 1 << (shadow + 1);
            if (fl) q.delete();
            else if (shadow != 3'd0 && shadow != 3'd7 && in_valid) begin
                q.push_back(int'($signed(data_in)));
                if (q.size() % r == 0) begin
                    pend = 1'b1;
                    cap_a = 25'(model(3, 25));
                    cap_b = 10'(model(1, 10));
                end
            end
            shadow = os_sel;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; os_sel = 3'd1; in_valid = 1'b1; data_in = 4'd5;
        for (int c = 0; c < 3; c++) begin
            tick();
            vec++;
            if ({out_valid, valid_b, flag_out, data_out, flag_b, data_b} !== '0)
                begin fails++; $display("FAIL reset: got a=%0b/%h b=%0b/%h want all 0", out_valid, {flag_out, data_out}, valid_b, {flag_b, data_b}); end
        end
        reset = 1'b0;
    endtask

    task automatic test_ramp();
        int k = 0;
        longint c3[4] = '{4, 56, 220, 560};
        os_sel = 3'd1; in_valid = 1'b1; data_in = 4'd1;
        for (int c = 0; c < 20; c++) begin
            tick();
            vec++;
            if ({out_valid, valid_b} !== {ev, ev}) begin fails++; $display("FAIL ramp valid: got %b want %b", {out_valid, valid_b}, {ev, ev}); end
            vec++;
            if ({flag_out, data_out} !== ea) begin fails++; $display("FAIL ramp data_a: got %h want %h", {flag_out, data_out}, ea); end
            vec++;
            if ({flag_b, data_b} !== eb) begin fails++; $display("FAIL ramp data_b: got %h want %h", {flag_b, data_b}, eb); end
            if (out_valid === 1'b1) begin
                vec++;
                if (k < 4 && {flag_out, data_out} !== 25'(c3[k])) begin fails++; $display("FAIL ramp const k=%0d: got %0d want %0d", k, {flag_out, data_out}, c3[k]); end
                k++;
            end
        end
        vec++;
        if (k != 4) begin fails++; $display("FAIL ramp strobe count: got %0d want 4", k); end
    endtask

    task automatic test_gaps();
        int k = 0;
        int last = -1;
        longint c3[4] = '{4, 56, 220, 560};
        reset = 1'b1; tick(); reset = 1'b0;
        os_sel = 3'd1; data_in = 4'd1;
        for (int c = 0; c < 160; c++) begin
            in_valid = (c % 3 == 0);
            tick();
            vec++;
            if ({out_valid, valid_b} !== {ev, ev}) begin fails++; $display("FAIL gaps valid: got %b want %b", {out_valid, valid_b}, {ev, ev}); end
            vec++;
            if ({flag_out, data_out} !== ea) begin fails++; $display("FAIL gaps data_a: got %h want %h", {flag_out, data_out}, ea); end
            vec++;
            if ({flag_b, data_b} !== eb) begin fails++; $display("FAIL gaps data_b: got %h want %h", {flag_b, data_b}, eb); end
            if (out_valid === 1'b1) begin
                if (k < 4) begin
                    vec++;
                    if ({flag_out, data_out} !== 25'(c3[k])) begin fails++; $display("FAIL gaps const k=%0d: got %0d want %0d", k, {flag_out, data_out}, c3[k]); end
                end
                if (last >= 0) begin
                    vec++;
                    if (c - last != 12) begin fails++; $display("FAIL gaps spacing: got %0d want 12", c - last); end
                end
                last = c;
                k++;
            end
        end
    endtask

    task automatic test_wrap();
        int k = 0;
        reset = 1'b1; tick(); reset = 1'b0;
        os_sel = 3'd1; in_valid = 1'b1; data_in = 4'd7;
        for (int c = 0; c < 170; c++) begin
            tick();
            vec++;
            if ({out_valid, valid_b} !== {ev, ev}) begin fails++; $display("FAIL wrap valid: got %b want %b", {out_valid, valid_b}, {ev, ev}); end
            vec++;
            if ({flag_b, data_b} !== eb) begin fails++; $display("FAIL wrap data_b: got %h want %h", {flag_b, data_b}, eb); end
            vec++;
            if ({flag_out, data_out} !== ea) begin fails++; $display("FAIL wrap data_a: got %h want %h", {flag_out, data_out}, ea); end
            if (valid_b === 1'b1) begin
                k++;
                if (k == 10) begin
                    vec++;
                    if ({flag_b, data_b} !== 10'd280) begin fails++; $display("FAIL wrap k10: got flag=%0d data=%0d want flag=1 data=24", flag_b, data_b); end
                end
            end
        end
    endtask

    task automatic test_negative();
        int k = 0;
        longint c3[4] = '{4, 56, 220, 560};
        reset = 1'b1; tick(); reset = 1'b0;
        os_sel = 3'd1; in_valid = 1'b1; data_in = 4'h8;
        for (int c = 0; c < 20; c++) begin
            tick();
            vec++;
            if ({flag_out, data_out} !== ea) begin fails++; $display("FAIL neg data_a: got %h want %h", {flag_out, data_out}, ea); end
            if (out_valid === 1'b1 && k < 4) begin
                vec++;
                if ({flag_out, data_out} !== 25'(-8 * c3[k])) begin fails++; $display("FAIL neg const k=%0d: got %h want %h", k, {flag_out, data_out}, 25'(-8 * c3[k])); end
                k++;
            end
        end
    endtask

    task automatic test_os_change();
        int first = -1;
        reset = 1'b1; tick(); reset = 1'b0;
        os_sel = 3'd1; in_valid = 1'b1; data_in = 4'd1;
        for (int c = 0; c < 3; c++) tick();
        os_sel = 3'd3;
        for (int c = 0; c < 18; c++) begin
            tick();
            vec++;
            if ({out_valid, valid_b} !== {ev, ev}) begin fails++; $display("FAIL oschg valid: got %b want %b", {out_valid, valid_b}, {ev, ev}); end
            if (out_valid === 1'b1 && first < 0) first = c;
        end
        vec++;
        if (first != 17) begin fails++; $display("FAIL oschg first strobe: got %0d want 17", first); end
        vec++;
        if ({flag_out, data_out} !== 25'd560) begin fails++; $display("FAIL oschg data: got %0d want 560", {flag_out, data_out}); end
    endtask

    task automatic test_disabled();
        int first = -1;
        os_sel = 3'd0;
        for (int c = 0; c < 200; c++) begin
            in_valid = 1'($urandom_range(1));
            data_in = 4'($urandom);
            tick();
            vec++;
            if ({out_valid, valid_b} !== 2'b00) begin fails++; $display("FAIL disabled valid: got %b want 00", {out_valid, valid_b}); end
        end
        os_sel = 3'd2; in_valid = 1'b1; data_in = 4'd1;
        for (int c = 0; c < 12 && first < 0; c++) begin
            tick();
            if (out_valid === 1'b1) first = c;
        end
        vec++;
        if (first < 0 || {flag_out, data_out} !== 25'd56) begin fails++; $display("FAIL disabled restart: strobe=%0d got %0d want 56", first, {flag_out, data_out}); end
    endtask

    task automatic test_reset_pending();
        bit found = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        os_sel = 3'd1; in_valid = 1'b1;
        for (int c = 0; c < 30 && !found; c++) begin
            data_in = 4'($urandom);
            tick();
            found = pend;
        end
        vec++;
        if (!found) begin fails++; $display("FAIL rstpend: no pending capture within 30 cycles"); end
        reset = 1'b1; tick(); reset = 1'b0;
        vec++;
        if ({out_valid, valid_b, flag_out, data_out, flag_b, data_b} !== '0)
            begin fails++; $display("FAIL rstpend outputs: got a=%0b/%h b=%0b/%h want all 0", out_valid, {flag_out, data_out}, valid_b, {flag_b, data_b}); end
        test_ramp();
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(499) == 0);
            if ($urandom_range(199) == 0) os_sel = 3'($urandom);
            in_valid = 1'($urandom_range(1));
            data_in = 4'($urandom);
            tick();
            vec++;
            if ({out_valid, valid_b} !== {ev, ev}) begin fails++; $display("FAIL rand valid c=%0d: got %b want %b", c, {out_valid, valid_b}, {ev, ev}); end
            vec++;
            if ({flag_out, data_out} !== ea) begin fails++; $display("FAIL rand data_a c=%0d: got %h want %h", c, {flag_out, data_out}, ea); end
            vec++;
            if ({flag_b, data_b} !== eb) begin fails++; $display("FAIL rand data_b c=%0d: got %h want %h", c, {flag_b, data_b}, eb); end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_gaps();
        test_wrap();
        test_negative();
        test_os_change();
        test_disabled();
        test_reset_pending();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
        $finish;
    end

endmodule
